// File: rtl/core_pkg.sv
// Shared integer-core constants and the register write request record.
package core_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Producer/register-file bundle for the writeback arbiter.
// The WB_BYPASS_EN macro adds the read-forwarding ports.
interface writeback_arbiter_if #(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int ADDR_W = core_pkg::ADDR_W
);

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              ll_valid;
    logic              ll_ready;
    logic [ADDR_W-1:0] ll_rd;
    logic [DATA_W-1:0] ll_data;

    logic              wb_we;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              ll_pending;

`ifdef WB_BYPASS_EN
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data, ll_valid, ll_rd, ll_data,
        output alu_ready, ll_ready, wb_we, wb_rd, wb_data, ll_pending
`ifdef WB_BYPASS_EN
        , input rs1, rs2, rf_data1, rf_data2,
        output fwd_data1, fwd_data2
`endif
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ll_valid, ll_rd, ll_data,
        input  alu_ready, ll_ready, wb_we, wb_rd, wb_data, ll_pending
`ifdef WB_BYPASS_EN
        , output rs1, rs2, rf_data1, rf_data2,
        input fwd_data1, fwd_data2
`endif
    );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Small synchronous FIFO buffering long-latency writeback results.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == (PW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = mem[rdPtr];

    // NOTE: storage has no reset; validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and long-latency results onto the single register-file write port.
// Define WB_BYPASS_EN to add same-cycle write/read forwarding outputs.
module writeback_arbiter #(
    parameter int DATA_W       = core_pkg::DATA_W,
    parameter int ADDR_W       = core_pkg::ADDR_W,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    writeback_arbiter_if.slave bus
);

    import core_pkg::*;

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);
    localparam int REQ_W = ADDR_W + DATA_W;
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic              aluReadyQ;
    logic              wbWeQ;
    logic [ADDR_W-1:0] wbRdQ;
    logic [DATA_W-1:0] wbDataQ;
    logic [SW-1:0]     starveQ;
    logic [SW-1:0]     starveNext;

    logic [CW-1:0]     fifoCount;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [REQ_W-1:0]  headReq;

    logic              llPush;
    logic              fifoPush;
    logic              fifoPop;
    logic              aluWin;
    logic              bypass;
    logic              selValid;
    logic [ADDR_W-1:0] selRd;
    logic [DATA_W-1:0] selData;

    assign bus.ll_ready   = !fifoFull;
    assign bus.ll_pending = (fifoCount != '0);
    assign bus.alu_ready  = aluReadyQ;
    assign bus.wb_we      = wbWeQ;
    assign bus.wb_rd      = wbRdQ;
    assign bus.wb_data    = wbDataQ;

    assign llPush   = bus.ll_valid && bus.ll_ready;
    assign fifoPush = llPush && !bypass;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        fifoPop  = 1'b0;
        aluWin   = 1'b0;
        bypass   = 1'b0;
        selRd    = bus.alu_rd;
        selData  = bus.alu_data;
        if (!aluReadyQ && !fifoEmpty)           fifoPop = 1'b1;
        else if (bus.alu_valid && aluReadyQ)    aluWin  = 1'b1;
        else if (!fifoEmpty)                    fifoPop = 1'b1;
        else if (llPush)                        bypass  = 1'b1;
        if (fifoPop)     {selRd, selData} = headReq;
        else if (bypass) {selRd, selData} = {bus.ll_rd, bus.ll_data};
        selValid = fifoPop || aluWin || bypass;
    end

    // Counts consecutive ALU wins over a waiting FIFO head.
    always_comb begin
        starveNext = starveQ;
        if (fifoPop || fifoEmpty)
            starveNext = '0;
        else if (aluWin && starveQ != LIMIT_C)
            starveNext = starveQ + SW'(1);
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aluReadyQ <= 1'b1;
            starveQ   <= '0;
            wbWeQ     <= 1'b0;
            wbRdQ     <= '0;
            wbDataQ   <= '0;
        end else begin
            starveQ   <= starveNext;
            aluReadyQ <= (starveNext != LIMIT_C);
            wbWeQ     <= selValid && (selRd != ADDR_W'(REG_ZERO));
            if (selValid) begin
                wbRdQ   <= selRd;
                wbDataQ <= selData;
            end
        end
    end

    wb_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (fifoPush),
        .pop    (fifoPop),
        .wrData ({bus.ll_rd, bus.ll_data}),
        .rdData (headReq),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

`ifdef WB_BYPASS_EN
    assign bus.fwd_data1 = (wbWeQ && wbRdQ == bus.rs1 && bus.rs1 != ADDR_W'(REG_ZERO))
                           ? wbDataQ : bus.rf_data1;
    assign bus.fwd_data2 = (wbWeQ && wbRdQ == bus.rs2 && bus.rs2 != ADDR_W'(REG_ZERO))
                           ? wbDataQ : bus.rf_data2;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed vectors, expected writes queued, monitor compares.
module tb_writeback_arbiter;

    import core_pkg::*;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    wb_req_t sb[$];

    writeback_arbiter_if bus();

    writeback_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic sbPush(input int rd, input logic [31:0] data);
        wb_req_t r;
        r.rd   = 5'(rd);
        r.data = data;
        sb.push_back(r);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ll_valid  = 1'b0;
        bus.ll_rd     = '0;
        bus.ll_data   = '0;
    endtask

    always @(negedge clk) begin
        if (rst && bus.wb_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("wb_unexpected_write", 64'(bus.wb_we), 64'(sb.size() != 0));
            end else begin
                wb_req_t e;
                e = sb.pop_front();
                check("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
                check("wb_data", 64'(bus.wb_data), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ai;
        int li;
        rst = 1'b0;
        idleInputs();
`ifdef WB_BYPASS_EN
        bus.rs1      = '0;
        bus.rs2      = '0;
        bus.rf_data1 = '0;
        bus.rf_data2 = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_we", 64'(bus.wb_we), 64'd0);
        check("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
        check("rst_wb_data", 64'(bus.wb_data), 64'd0);
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("rst_ll_ready", 64'(bus.ll_ready), 64'd1);
        check("rst_ll_pending", 64'(bus.ll_pending), 64'd0);
        rst = 1'b1;
        cyc();

        // ALU only: one-cycle latency.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        sbPush(5, 32'hDEADBEEF);
        cyc();
        check("alu_latency_we", 64'(bus.wb_we), 64'd1);
        idleInputs();
        cyc();

        // Long-latency bypass with an empty FIFO.
        bus.ll_valid = 1'b1;
        bus.ll_rd    = 5'd7;
        bus.ll_data  = 32'h12345678;
        sbPush(7, 32'h12345678);
        #3;
        check("bypass_ll_ready", 64'(bus.ll_ready), 64'd1);
        cyc();
        check("bypass_we", 64'(bus.wb_we), 64'd1);
        check("bypass_pending", 64'(bus.ll_pending), 64'd0);
        idleInputs();
        cyc();

        // Collision: ALU every cycle, three ll offers; starvation forces one FIFO win.
        for (int i = 0; i < 5; i++) sbPush(16 + i, 32'hA000_0000 + 32'(i));
        sbPush(1, 32'hB000_0001);
        sbPush(21, 32'hA000_0005);
        sbPush(2, 32'hB000_0002);
        sbPush(3, 32'hB000_0003);
        ai = 0;
        li = 0;
        for (int k = 0; k < 9; k++) begin
            logic aluTaken;
            logic llTaken;
            bus.alu_valid = (k <= 6);
            bus.alu_rd    = 5'(16 + ai);
            bus.alu_data  = 32'hA000_0000 + 32'(ai);
            bus.ll_valid  = (li < 3);
            bus.ll_rd     = 5'(li + 1);
            bus.ll_data   = 32'hB000_0000 + 32'(li + 1);
            #3;
            if (k == 2) check("full_ll_ready", 64'(bus.ll_ready), 64'd0);
            if (k == 4) check("pre_stall_alu_ready", 64'(bus.alu_ready), 64'd1);
            if (k == 5) check("stall_alu_ready", 64'(bus.alu_ready), 64'd0);
            if (k == 5) check("stall_ll_ready", 64'(bus.ll_ready), 64'd0);
            if (k == 6) check("post_stall_alu_ready", 64'(bus.alu_ready), 64'd1);
            aluTaken = bus.alu_valid && bus.alu_ready;
            llTaken  = bus.ll_valid && bus.ll_ready;
            cyc();
            if (aluTaken) ai++;
            if (llTaken)  li++;
        end
        idleInputs();
        check("collision_drained", 64'(bus.ll_pending), 64'd0);
        cyc();

        // x0: ALU rd=0 is dropped, ll rd=0 entry queues then pops silently.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'hFFFFFFFF;
        bus.ll_valid  = 1'b1;
        bus.ll_rd     = 5'd0;
        bus.ll_data   = 32'h0000_0055;
        cyc();
        idleInputs();
        check("x0_alu_we", 64'(bus.wb_we), 64'd0);
        check("x0_pending_set", 64'(bus.ll_pending), 64'd1);
        cyc();
        check("x0_ll_we", 64'(bus.wb_we), 64'd0);
        check("x0_pending_clr", 64'(bus.ll_pending), 64'd0);
        cyc();

        // Reset mid-stream with two entries queued.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
        bus.ll_valid  = 1'b1; bus.ll_rd  = 5'd20; bus.ll_data = 32'h2020;
        sbPush(3, 32'h33);
        cyc();
        bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
        bus.ll_rd  = 5'd21; bus.ll_data = 32'h2121;
        sbPush(4, 32'h44);
        cyc();
        bus.alu_rd = 5'd5; bus.alu_data = 32'h55;
        bus.ll_valid = 1'b0;
        sbPush(5, 32'h55);
        cyc();
        idleInputs();
        check("pre_rst_pending", 64'(bus.ll_pending), 64'd1);
        check("pre_rst_we", 64'(bus.wb_we), 64'd1);
        #6;
        rst = 1'b0;
        #1;
        check("async_rst_we", 64'(bus.wb_we), 64'd0);
        check("async_rst_pending", 64'(bus.ll_pending), 64'd0);
        check("async_rst_ll_ready", 64'(bus.ll_ready), 64'd1);
        repeat (2) cyc();
        rst = 1'b1;
        repeat (4) cyc();
        check("post_rst_pending", 64'(bus.ll_pending), 64'd0);
        check("post_rst_we", 64'(bus.wb_we), 64'd0);

`ifdef WB_BYPASS_EN
        bus.rs1       = 5'd9;
        bus.rf_data1  = 32'h0;
        bus.rs2       = 5'd0;
        bus.rf_data2  = 32'h1234_5678;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd9;
        bus.alu_data  = 32'hA5A5A5A5;
        sbPush(9, 32'hA5A5A5A5);
        cyc();
        idleInputs();
        check("fwd1_hit", 64'(bus.fwd_data1), 64'hA5A5A5A5);
        check("fwd2_x0", 64'(bus.fwd_data2), 64'h1234_5678);
        bus.rs1      = 5'd8;
        bus.rf_data1 = 32'h77;
        #1;
        check("fwd1_miss", 64'(bus.fwd_data1), 64'h77);
        cyc();
`endif

        repeat (3) cyc();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
